// File: rtl/dma_desc_queue_pkg.sv
// Shared descriptor/response types for the DMA descriptor queueing stage.
// The ADDR_WIDTH localparam fixes the address field width of dma_desc_t.
package dma_desc_pkg;

   localparam int ADDR_WIDTH = 16;
   localparam int DESC_W     = 29 + 2 * ADDR_WIDTH;
   localparam int RESP_W     = 10;

   localparam int ERR_RESP_UNDERFLOW = 0;
   localparam int ERR_DESC_REJECT    = 1;

   typedef struct packed {
      logic                  endian;
      logic                  write;
      logic [1:0]            ch_sel;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic [3:0]            sel;
      logic [7:0]            id;
      logic [ADDR_WIDTH-1:0] dma_addr;
      logic [ADDR_WIDTH-1:0] mem_addr;
   } dma_desc_t;

   typedef struct packed {
      logic [7:0] id;
      logic [1:0] ch_sel;
   } dma_resp_t;

   // A descriptor the DMA core cannot execute: empty, bad channel, oversize beat or reserved burst.
   function automatic logic descRejected(input dma_desc_t d, input int numCh);
      return (d.len == 8'd0) || (int'(d.ch_sel) >= numCh) ||
             (d.size > 3'd3) || (d.burst == 2'b11);
   endfunction

endpackage

// File: rtl/dma_desc_queue_fifo.sv
// Count-based first-word fall-through synchronous FIFO; the caller qualifies push/pop strobes.
// o_countNext exposes the count the next edge will load, for registered status derived downstream.
module dma_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic [AW:0]      o_count,
   output logic [AW:0]      o_countNext,
   output logic             o_full,
   output logic             o_empty
);

   localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

   logic [WIDTH-1:0] r_mem [2**AW];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == DEPTH);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rdPtr];
   assign w_push  = i_push && !o_full && !i_flush;
   assign w_pop   = i_pop && !o_empty && !i_flush;

   always_comb begin
      o_countNext = r_count;
      if (i_flush)
         o_countNext = '0;
      else if (w_push && !w_pop)
         o_countNext = r_count + (AW+1)'(1);
      else if (w_pop && !w_push)
         o_countNext = r_count - (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
         r_count <= o_countNext;
      end
   end

   // Storage is deliberately not reset; only pointers/count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr] <= i_data;
   end

endmodule

// File: rtl/dma_desc_queue.sv
// Descriptor and response queues in front of the DMA core, with outstanding tracking and status.
// Define DMA_DESC_CHECK_EN to drop malformed host descriptors and flag them in o_err[1].
module dma_desc_queue
   import dma_desc_pkg::*;
#(
   parameter int APB_STR_CHA  = 2,
   parameter int DESC_FIFO_AW = 3,
   parameter int RESP_FIFO_AW = 3,
   parameter int OUTST_W      = 8
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic               aenable,
   input  logic               i_flush,
   input  logic               i_host_desc_valid,
   input  logic [DESC_W-1:0]  i_host_desc,
   output logic               o_host_desc_ready,
   output logic               o_desc_rready,
   output logic [DESC_W-1:0]  o_desc,
   input  logic               i_desc_rd,
   output logic               o_resp_wready,
   input  logic               i_resp_wr,
   input  logic [RESP_W-1:0]  i_resp,
   output logic               o_host_resp_valid,
   output logic [RESP_W-1:0]  o_host_resp,
   input  logic               i_host_resp_ready,
   output logic [OUTST_W-1:0] o_outstanding,
   output logic               o_idle,
   output logic [1:0]         o_err
);

   logic                  w_active;
   logic                  w_descFull, w_descEmpty, w_respFull, w_respEmpty;
   logic [DESC_FIFO_AW:0] w_descCount, w_descCountNext;
   logic [RESP_FIFO_AW:0] w_respCount, w_respCountNext;
   logic                  w_descAccept, w_descWr, w_descPop, w_respPush, w_respPop;
   logic                  w_reject, w_outstSat, w_underflow;
   logic [OUTST_W-1:0]    w_outstNext;
   logic [OUTST_W-1:0]    r_outst;
   logic [1:0]            r_err;
   logic                  r_idle;

   // Handshake outputs drop immediately on reset or disable, independent of the registered counts.
   assign w_active          = aenable && !areset;
   assign w_outstSat        = &r_outst;
   assign o_host_desc_ready = w_active && !w_descFull && !w_outstSat;
   assign o_desc_rready     = w_active && !w_descEmpty;
   assign o_resp_wready     = w_active && !w_respFull;
   assign o_host_resp_valid = w_active && !w_respEmpty;

   assign w_descAccept = i_host_desc_valid && o_host_desc_ready && !i_flush;
   assign w_descWr     = w_descAccept && !w_reject;
   assign w_descPop    = i_desc_rd && o_desc_rready && !i_flush;
   assign w_respPush   = i_resp_wr && o_resp_wready && !i_flush;
   assign w_respPop    = i_host_resp_ready && o_host_resp_valid && !i_flush;

`ifdef DMA_DESC_CHECK_EN
   dma_desc_t w_hostDesc;
   assign w_hostDesc = dma_desc_t'(i_host_desc);
   assign w_reject   = descRejected(w_hostDesc, APB_STR_CHA);
`else
   assign w_reject   = 1'b0;
`endif

   dma_sync_fifo #(.WIDTH(DESC_W), .AW(DESC_FIFO_AW)) u_descFifo (
      .clk(aclk), .rst(areset), .i_flush(i_flush),
      .i_push(w_descWr), .i_pop(w_descPop), .i_data(i_host_desc),
      .o_data(o_desc), .o_count(w_descCount), .o_countNext(w_descCountNext),
      .o_full(w_descFull), .o_empty(w_descEmpty)
   );

   dma_sync_fifo #(.WIDTH(RESP_W), .AW(RESP_FIFO_AW)) u_respFifo (
      .clk(aclk), .rst(areset), .i_flush(i_flush),
      .i_push(w_respPush), .i_pop(w_respPop), .i_data(i_resp),
      .o_data(o_host_resp), .o_count(w_respCount), .o_countNext(w_respCountNext),
      .o_full(w_respFull), .o_empty(w_respEmpty)
   );

   // A response with nothing outstanding is an underflow; the counter pins at zero.
   always_comb begin
      w_outstNext = r_outst;
      w_underflow = 1'b0;
      if (w_descPop && !w_respPush) begin
         if (!w_outstSat) w_outstNext = r_outst + OUTST_W'(1);
      end else if (w_respPush && !w_descPop) begin
         if (r_outst == '0) w_underflow = 1'b1;
         else               w_outstNext = r_outst - OUTST_W'(1);
      end
   end

   // Flush leaves the outstanding count alone since in-flight responses still return.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_outst <= '0;
         r_err   <= '0;
         r_idle  <= 1'b1;
      end else if (i_flush) begin
         r_err  <= '0;
         r_idle <= (r_outst == '0);
      end else if (aenable) begin
         r_outst <= w_outstNext;
         if (w_underflow)             r_err[ERR_RESP_UNDERFLOW] <= 1'b1;
         if (w_descAccept && w_reject) r_err[ERR_DESC_REJECT]   <= 1'b1;
         r_idle <= (w_descCountNext == '0) && (w_respCountNext == '0) && (w_outstNext == '0);
      end
   end

   assign o_outstanding = r_outst;
   assign o_idle        = r_idle;
   assign o_err         = r_err;

endmodule

// File: tb/tb_dma_desc_queue.sv
// Scoreboard bench for dma_desc_queue: queue models of both FIFOs plus outstanding/error/idle model.
// Expectations for rejected descriptors follow DMA_DESC_CHECK_EN.
module tb_dma_desc_queue;
   import dma_desc_pkg::*;

   localparam int DEPTH = 8;

   logic              aclk = 1'b0;
   logic              areset;
   logic              aenable;
   logic              i_flush;
   logic              i_host_desc_valid;
   dma_desc_t         i_host_desc;
   logic              o_host_desc_ready;
   logic              o_desc_rready;
   dma_desc_t         o_desc;
   logic              i_desc_rd;
   logic              o_resp_wready;
   logic              i_resp_wr;
   dma_resp_t         i_resp;
   logic              o_host_resp_valid;
   dma_resp_t         o_host_resp;
   logic              i_host_resp_ready;
   logic [7:0]        o_outstanding;
   logic              o_idle;
   logic [1:0]        o_err;

   dma_desc_t descQ[$];
   dma_resp_t respQ[$];
   int        modelOutst;
   logic [1:0] modelErr;
   int        compareCount;
   int        mismatchCount;

   dma_desc_queue dut (
      .aclk(aclk), .areset(areset), .aenable(aenable), .i_flush(i_flush),
      .i_host_desc_valid(i_host_desc_valid), .i_host_desc(i_host_desc),
      .o_host_desc_ready(o_host_desc_ready), .o_desc_rready(o_desc_rready),
      .o_desc(o_desc), .i_desc_rd(i_desc_rd), .o_resp_wready(o_resp_wready),
      .i_resp_wr(i_resp_wr), .i_resp(i_resp), .o_host_resp_valid(o_host_resp_valid),
      .o_host_resp(o_host_resp), .i_host_resp_ready(i_host_resp_ready),
      .o_outstanding(o_outstanding), .o_idle(o_idle), .o_err(o_err)
   );

   always #5 aclk = ~aclk;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   function automatic bit isRejected(input dma_desc_t d);
      bit rej;
      rej = 1'b0;
`ifdef DMA_DESC_CHECK_EN
      rej = (d.len == 8'd0) || (d.ch_sel >= 2'd2) || (d.size > 3'd3) || (d.burst == 2'b11);
`endif
      return rej;
   endfunction

   function automatic dma_desc_t makeDesc(input logic [7:0] id, input logic [7:0] len, input logic [1:0] ch);
      dma_desc_t d;
      d          = '0;
      d.id       = id;
      d.len      = len;
      d.ch_sel   = ch;
      d.size     = 3'd2;
      d.burst    = 2'b01;
      d.sel      = 4'hf;
      d.write    = id[0];
      d.dma_addr = 16'h1000 + {8'h00, id};
      d.mem_addr = 16'h8000 ^ {id, id};
      return d;
   endfunction

   function automatic dma_resp_t makeResp(input logic [7:0] id, input logic [1:0] ch);
      dma_resp_t r;
      r.id     = id;
      r.ch_sel = ch;
      return r;
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // One clock of activity on any combination of the four handshake ports, checked against the model.
   task automatic applyStimulus(input bit doPush, input dma_desc_t desc, input bit doPop,
                                input bit doResp, input dma_resp_t resp, input bit doHostPop);
      bit expDescReady, pushed, popped, respPushed, hostPopped;
      expDescReady = (descQ.size() < DEPTH) && (modelOutst != 255);
      checkOutput("descReady", 64'(o_host_desc_ready), 64'(expDescReady));
      checkOutput("descRready", 64'(o_desc_rready), 64'(descQ.size() != 0));
      checkOutput("respWready", 64'(o_resp_wready), 64'(respQ.size() < DEPTH));
      checkOutput("respValid", 64'(o_host_resp_valid), 64'(respQ.size() != 0));
      popped     = doPop && (descQ.size() != 0);
      pushed     = doPush && expDescReady && !isRejected(desc);
      respPushed = doResp && (respQ.size() < DEPTH);
      hostPopped = doHostPop && (respQ.size() != 0);
      if (popped)     checkOutput("descHead", 64'(o_desc), 64'(descQ[0]));
      if (hostPopped) checkOutput("respHead", 64'(o_host_resp), 64'(respQ[0]));
      i_host_desc_valid = doPush;
      i_host_desc       = desc;
      i_desc_rd         = doPop;
      i_resp_wr         = doResp;
      i_resp            = resp;
      i_host_resp_ready = doHostPop;
      tick();
      i_host_desc_valid = 1'b0;
      i_desc_rd         = 1'b0;
      i_resp_wr         = 1'b0;
      i_host_resp_ready = 1'b0;
      if (popped)     void'(descQ.pop_front());
      if (pushed)     descQ.push_back(desc);
      if (hostPopped) void'(respQ.pop_front());
      if (respPushed) respQ.push_back(resp);
      if (doPush && expDescReady && isRejected(desc)) modelErr[1] = 1'b1;
      if (popped && !respPushed) begin
         if (modelOutst != 255) modelOutst++;
      end else if (respPushed && !popped) begin
         if (modelOutst == 0) modelErr[0] = 1'b1;
         else                 modelOutst--;
      end
      checkOutput("outstanding", 64'(o_outstanding), 64'(modelOutst));
      checkOutput("err", 64'(o_err), 64'(modelErr));
      checkOutput("idle", 64'(o_idle),
                  64'(descQ.size() == 0 && respQ.size() == 0 && modelOutst == 0));
   endtask

   task automatic pushDesc(input logic [7:0] id, input logic [7:0] len, input logic [1:0] ch);
      applyStimulus(1'b1, makeDesc(id, len, ch), 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic popDesc();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
   endtask

   task automatic pushResp(input logic [7:0] id);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, makeResp(id, 2'd1), 1'b0);
   endtask

   task automatic hostPop();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   // Flush cycle also carries a push and a pop that must be discarded.
   task automatic applyFlush();
      i_flush           = 1'b1;
      i_host_desc_valid = 1'b1;
      i_host_desc       = makeDesc(8'h99, 8'd4, 2'd0);
      i_desc_rd         = 1'b1;
      tick();
      i_flush           = 1'b0;
      i_host_desc_valid = 1'b0;
      i_desc_rd         = 1'b0;
      descQ.delete();
      respQ.delete();
      modelErr = 2'b00;
      checkOutput("flushRready", 64'(o_desc_rready), 64'(0));
      checkOutput("flushRespValid", 64'(o_host_resp_valid), 64'(0));
      checkOutput("flushErr", 64'(o_err), 64'(0));
      checkOutput("flushOutst", 64'(o_outstanding), 64'(modelOutst));
   endtask

   initial begin
      compareCount      = 0;
      mismatchCount     = 0;
      modelOutst        = 0;
      modelErr          = 2'b00;
      areset            = 1'b1;
      aenable           = 1'b1;
      i_flush           = 1'b0;
      i_host_desc_valid = 1'b0;
      i_host_desc       = '0;
      i_desc_rd         = 1'b0;
      i_resp_wr         = 1'b0;
      i_resp            = '0;
      i_host_resp_ready = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      checkOutput("rstIdle", 64'(o_idle), 64'(1));
      checkOutput("rstOutst", 64'(o_outstanding), 64'(0));
      checkOutput("rstErr", 64'(o_err), 64'(0));
      checkOutput("rstDescReady", 64'(o_host_desc_ready), 64'(0));
      checkOutput("rstRespWready", 64'(o_resp_wready), 64'(0));
      areset = 1'b0;
      tick();
      checkOutput("postRstReady", 64'(o_host_desc_ready), 64'(1));

      $display("[TB] fill and drain descriptor FIFO");
      for (int i = 0; i < 9; i++) pushDesc(8'(i), 8'd4, 2'd0);
      checkOutput("fullReady", 64'(o_host_desc_ready), 64'(0));
      for (int i = 0; i < 8; i++) popDesc();
      checkOutput("drainedRready", 64'(o_desc_rready), 64'(0));
      checkOutput("outst8", 64'(o_outstanding), 64'(8));
      for (int i = 0; i < 8; i++) pushResp(8'(i + 16));
      for (int i = 0; i < 8; i++) hostPop();

      $display("[TB] empty pop and same-cycle push/pop");
      popDesc();
      checkOutput("emptyPopOutst", 64'(o_outstanding), 64'(0));
      pushDesc(8'd20, 8'd4, 2'd1);
      applyStimulus(1'b1, makeDesc(8'd21, 8'd2, 2'd0), 1'b1, 1'b0, '0, 1'b0);
      checkOutput("sameCycleOutst", 64'(o_outstanding), 64'(1));
      checkOutput("sameCycleHead", 64'(o_desc.id), 64'(21));
      popDesc();
      checkOutput("sameCycleCount1", 64'(o_desc_rready), 64'(0));
      pushResp(8'd20);
      pushResp(8'd21);
      hostPop();
      hostPop();

      $display("[TB] three descriptors, three responses");
      for (int i = 0; i < 3; i++) pushDesc(8'(i + 5), 8'd8, 2'd1);
      for (int i = 0; i < 3; i++) popDesc();
      checkOutput("outst3", 64'(o_outstanding), 64'(3));
      for (int i = 5; i < 8; i++) pushResp(8'(i));
      checkOutput("outst0", 64'(o_outstanding), 64'(0));
      hostPop();
      hostPop();
      checkOutput("notIdleYet", 64'(o_idle), 64'(0));
      hostPop();
      checkOutput("idleAfterPop", 64'(o_idle), 64'(1));

      $display("[TB] response underflow");
      pushResp(8'd42);
      checkOutput("underflowErr", 64'(o_err), 64'(1));
      hostPop();
      hostPop();
      checkOutput("underflowSticky", 64'(o_err[0]), 64'(1));
      pushDesc(8'd30, 8'd4, 2'd0);
      applyFlush();
      checkOutput("postFlushIdle", 64'(o_idle), 64'(1));

      $display("[TB] malformed descriptors");
      pushDesc(8'd50, 8'd0, 2'd0);
      pushDesc(8'd51, 8'd4, 2'd2);
`ifdef DMA_DESC_CHECK_EN
      checkOutput("rejectRready", 64'(o_desc_rready), 64'(0));
      checkOutput("rejectErr", 64'(o_err[1]), 64'(1));
`else
      checkOutput("acceptRready", 64'(o_desc_rready), 64'(1));
      checkOutput("acceptErr", 64'(o_err[1]), 64'(0));
`endif
      while (descQ.size() != 0) popDesc();
      popDesc();
      while (modelOutst != 0) pushResp(8'd60);
      while (respQ.size() != 0) hostPop();
      applyFlush();

      $display("[TB] clock enable low");
      pushDesc(8'd70, 8'd4, 2'd0);
      aenable = 1'b0;
      #1;
      checkOutput("disDescReady", 64'(o_host_desc_ready), 64'(0));
      checkOutput("disRready", 64'(o_desc_rready), 64'(0));
      i_desc_rd = 1'b1;
      tick();
      i_desc_rd = 1'b0;
      checkOutput("disHoldOutst", 64'(o_outstanding), 64'(0));
      aenable = 1'b1;
      #1;
      checkOutput("enRready", 64'(o_desc_rready), 64'(1));
      tick();
      popDesc();
      pushResp(8'd70);
      hostPop();

      $display("[TB] reset mid-stream");
      for (int i = 0; i < 4; i++) pushDesc(8'(i + 80), 8'd4, 2'd0);
      popDesc();
      #2;
      areset = 1'b1;
      #1;
      checkOutput("midRstRready", 64'(o_desc_rready), 64'(0));
      checkOutput("midRstOutst", 64'(o_outstanding), 64'(0));
      checkOutput("midRstIdle", 64'(o_idle), 64'(1));
      checkOutput("midRstDescReady", 64'(o_host_desc_ready), 64'(0));
      tick();
      areset = 1'b0;
      descQ.delete();
      respQ.delete();
      modelOutst = 0;
      modelErr   = 2'b00;
      tick();
      checkOutput("postMidRstRready", 64'(o_desc_rready), 64'(0));
      checkOutput("postMidRstIdle", 64'(o_idle), 64'(1));
      pushDesc(8'd90, 8'd4, 2'd0);
      popDesc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
